// File: rtl/tx_sweep_ctrl.sv
// TX chirp sweep sequencer: steps freq_code from F1 to F2 on each syncpulse,
// handing every code to TX over valid/ready and aborting on feedback overrun.
// Optional: define TX_SWEEP_PINGPONG_EN to add a down-leg from F2 back to F1.
module tx_sweep_ctrl #(
   parameter int          FW        = 16,
   parameter int          IW        = 32,
   parameter int unsigned STEP      = 40,
   parameter int          DWELL_CYC = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          syncpulse,
   input  logic [FW-1:0] F1,
   input  logic [FW-1:0] F2,
   input  logic [IW-1:0] i_fid,
   input  logic [IW-1:0] i_set,
   output logic [FW-1:0] freq_code,
   output logic          freq_valid,
   input  logic          freq_ready,
   output logic          tx_en,
   output logic          busy,
   output logic          done,
   output logic          fault,
   output logic          cfg_err,
   output logic          sync_ovr
);

   localparam int            CW         = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
   localparam logic [FW:0]   STEP_W     = (FW+1)'(STEP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PRESENT,
      S_DWELL,
      S_DONE,
      S_FAULT
   } state_t;

   state_t        state;
   logic          sync_q;
   logic          sync_rise;
   logic [FW-1:0] f1_lat;
   logic [FW-1:0] f2_lat;
   logic [CW-1:0] dwell_cnt;
   logic          fb_hit;
   logic          sweep_active;
   logic [FW:0]   up_sum;
   logic [FW-1:0] up_code;

   assign sync_rise    = syncpulse & ~sync_q;
   assign fb_hit       = $signed(i_fid) >= $signed(i_set);
   assign sweep_active = (state == S_LOAD) || (state == S_PRESENT) || (state == S_DWELL);

   // The sum is one bit wider so a carry-out is caught by the clamp to F2.
   assign up_sum  = {1'b0, freq_code} + STEP_W;
   assign up_code = (up_sum > {1'b0, f2_lat}) ? f2_lat : up_sum[FW-1:0];

`ifdef TX_SWEEP_PINGPONG_EN
   logic          dir_down;
   logic [FW:0]   dn_diff;
   logic [FW-1:0] dn_code;

   // A borrow or a result below F1 clamps to F1, so the down-leg ends exactly on F1.
   assign dn_diff = {1'b0, freq_code} - STEP_W;
   assign dn_code = (dn_diff[FW] || (dn_diff[FW-1:0] < f1_lat)) ? f1_lat : dn_diff[FW-1:0];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         sync_q     <= 1'b0;
         f1_lat     <= '0;
         f2_lat     <= '0;
         dwell_cnt  <= '0;
         freq_code  <= '0;
         freq_valid <= 1'b0;
         tx_en      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         cfg_err    <= 1'b0;
         sync_ovr   <= 1'b0;
`ifdef TX_SWEEP_PINGPONG_EN
         dir_down   <= 1'b0;
`endif
      end else begin
         sync_q <= syncpulse;
         done   <= 1'b0;

         case (state)
            S_IDLE, S_DONE, S_FAULT: begin
               if (state == S_DONE) begin
                  state <= S_IDLE;
               end
               if (sync_rise) begin
                  fault    <= 1'b0;
                  sync_ovr <= 1'b0;
                  if (F1 <= F2) begin
                     f1_lat  <= F1;
                     f2_lat  <= F2;
                     cfg_err <= 1'b0;
                     state   <= S_LOAD;
                  end else begin
                     cfg_err <= 1'b1;
                     state   <= S_IDLE;
                  end
               end
            end

            S_LOAD: begin
               freq_code  <= f1_lat;
               freq_valid <= 1'b1;
               tx_en      <= 1'b1;
               busy       <= 1'b1;
`ifdef TX_SWEEP_PINGPONG_EN
               dir_down   <= 1'b0;
`endif
               state      <= S_PRESENT;
            end

            S_PRESENT: begin
               if (fb_hit) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  tx_en      <= 1'b0;
                  busy       <= 1'b0;
                  freq_valid <= 1'b0;
               end else if (freq_ready) begin
                  freq_valid <= 1'b0;
                  dwell_cnt  <= DWELL_LAST;
                  state      <= S_DWELL;
               end
            end

            // Feedback overrun outranks dwell expiry in the same cycle.
            S_DWELL: begin
               if (fb_hit) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  tx_en      <= 1'b0;
                  busy       <= 1'b0;
                  freq_valid <= 1'b0;
               end else if (dwell_cnt != '0) begin
                  dwell_cnt <= dwell_cnt - CW'(1);
               end else begin
`ifdef TX_SWEEP_PINGPONG_EN
                  if (!dir_down && (freq_code != f2_lat)) begin
                     freq_code  <= up_code;
                     freq_valid <= 1'b1;
                     state      <= S_PRESENT;
                  end else if (!dir_down && (freq_code != f1_lat)) begin
                     dir_down   <= 1'b1;
                     freq_code  <= dn_code;
                     freq_valid <= 1'b1;
                     state      <= S_PRESENT;
                  end else if (dir_down && (freq_code != f1_lat)) begin
                     freq_code  <= dn_code;
                     freq_valid <= 1'b1;
                     state      <= S_PRESENT;
                  end else begin
                     done  <= 1'b1;
                     tx_en <= 1'b0;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end
`else
                  if (freq_code != f2_lat) begin
                     freq_code  <= up_code;
                     freq_valid <= 1'b1;
                     state      <= S_PRESENT;
                  end else begin
                     done  <= 1'b1;
                     tx_en <= 1'b0;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end
`endif
               end
            end

            default: begin
               state      <= S_IDLE;
               freq_valid <= 1'b0;
               tx_en      <= 1'b0;
               busy       <= 1'b0;
            end
         endcase

         if (sync_rise && sweep_active) begin
            sync_ovr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tx_sweep_ctrl.sv
// Self-checking bench for tx_sweep_ctrl: a code-list reference model built from
// the sweep rules is compared against the codes accepted over the handshake.
module tb_tx_sweep_ctrl;

   localparam int FW        = 16;
   localparam int IW        = 32;
   localparam int STEP      = 40;
   localparam int DWELL_CYC = 4;
   localparam int BUDGET    = 6000;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 syncpulse = 1'b0;
   logic [FW-1:0]        F1 = '0;
   logic [FW-1:0]        F2 = '0;
   logic signed [IW-1:0] i_fid = '0;
   logic signed [IW-1:0] i_set = 32767;
   logic                 freq_ready = 1'b0;
   logic [FW-1:0]        freq_code;
   logic                 freq_valid;
   logic                 tx_en;
   logic                 busy;
   logic                 done;
   logic                 fault;
   logic                 cfg_err;
   logic                 sync_ovr;

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];
   int got_q[$];

   tx_sweep_ctrl #(
      .FW(FW), .IW(IW), .STEP(STEP), .DWELL_CYC(DWELL_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .syncpulse(syncpulse), .F1(F1), .F2(F2),
      .i_fid(i_fid), .i_set(i_set), .freq_code(freq_code), .freq_valid(freq_valid),
      .freq_ready(freq_ready), .tx_en(tx_en), .busy(busy), .done(done),
      .fault(fault), .cfg_err(cfg_err), .sync_ovr(sync_ovr)
   );

   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the list of codes a sweep should offer, derived directly from the sweep rules.
   function automatic void build_exp(int f1, int f2);
      int c;
      exp_q.delete();
      c = f1;
      exp_q.push_back(c);
      while (c < f2) begin
         c = (c + STEP > f2) ? f2 : c + STEP;
         exp_q.push_back(c);
      end
`ifdef TX_SWEEP_PINGPONG_EN
      while (c > f1) begin
         c = (c - STEP < f1) ? f1 : c - STEP;
         exp_q.push_back(c);
      end
`endif
   endfunction

   task automatic check_all_zero(string name);
      n_vec++;
      if ({freq_code, freq_valid, tx_en, busy, done, fault, cfg_err, sync_ovr} !== '0) begin
         n_err++;
         $display("[TB] FAIL %s: outputs code=%0d v=%b en=%b busy=%b done=%b flt=%b cfg=%b ovr=%b, required all 0",
                  name, freq_code, freq_valid, tx_en, busy, done, fault, cfg_err, sync_ovr);
      end
   endtask

   task automatic start_sweep(int f1, int f2);
      F1 = FW'(f1);
      F2 = FW'(f2);
      syncpulse = 1'b1;
      tick();
      syncpulse = 1'b0;
   endtask

   task automatic run_check(string name, int f1, int f2, bit rand_ready,
                            int stall_code, int stall_len, bit mid_sync);
      int            gap;
      int            stalls;
      int            done_cnt;
      bit            finished;
      bit            holding;
      logic [FW-1:0] held;
      build_exp(f1, f2);
      got_q.delete();
      gap = -1;
      stalls = stall_len;
      done_cnt = 0;
      finished = 1'b0;
      holding = 1'b0;
      held = '0;
      start_sweep(f1, f2);
      n_vec++;
      if (cfg_err !== 1'b0 || fault !== 1'b0 || sync_ovr !== 1'b0 || freq_valid !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL %s start_flags: cfg=%b flt=%b ovr=%b v=%b, required 0000",
                  name, cfg_err, fault, sync_ovr, freq_valid);
      end
      for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
         tick();
         if (syncpulse) syncpulse = 1'b0;
         if (done === 1'b1) begin
            done_cnt++;
            finished = 1'b1;
            n_vec++;
            if (tx_en !== 1'b0 || busy !== 1'b0 || freq_valid !== 1'b0 || gap != DWELL_CYC) begin
               n_err++;
               $display("[TB] FAIL %s done_cycle: en=%b busy=%b v=%b gap=%0d, required 0 0 0 gap=%0d",
                        name, tx_en, busy, freq_valid, gap, DWELL_CYC);
            end
         end else if (fault !== 1'b0) begin
            finished = 1'b1;
            n_vec++;
            n_err++;
            $display("[TB] FAIL %s unexpected_fault: got %b required 0", name, fault);
         end else if (freq_valid === 1'b1) begin
            n_vec++;
            if (tx_en !== 1'b1 || busy !== 1'b1 || (gap >= 0 && gap != DWELL_CYC) ||
                (holding && freq_code !== held)) begin
               n_err++;
               $display("[TB] FAIL %s present: en=%b busy=%b gap=%0d code=%0d held=%0d, required 1 1 gap=%0d stable",
                        name, tx_en, busy, gap, freq_code, held, DWELL_CYC);
            end
            gap = -1;
            if (int'(freq_code) == stall_code && stalls > 0) begin
               freq_ready = 1'b0;
               stalls--;
               if (mid_sync && stalls == stall_len / 2) syncpulse = 1'b1;
            end else begin
               freq_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (freq_ready) begin
               got_q.push_back(int'(freq_code));
               holding = 1'b0;
               gap = 0;
            end else begin
               holding = 1'b1;
               held = freq_code;
            end
         end else begin
            if (gap >= 0) gap++;
            freq_ready = 1'($urandom_range(0, 1));
         end
      end
      freq_ready = 1'b0;
      n_vec++;
      if (done_cnt != 1) begin
         n_err++;
         $display("[TB] FAIL %s timeout_or_done: done pulses %0d, required 1", name, done_cnt);
      end
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("[TB] FAIL %s code_count: got %0d required %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] != exp_q[i]) begin
            n_err++;
            $display("[TB] FAIL %s code[%0d]: got %0d required %0d", name, i, got_q[i], exp_q[i]);
         end
      end
      n_vec++;
      if (sync_ovr !== mid_sync) begin
         n_err++;
         $display("[TB] FAIL %s sync_ovr: got %b required %b", name, sync_ovr, mid_sync);
      end
      tick();
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || tx_en !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL %s after_done: done=%b busy=%b en=%b, required 000", name, done, busy, tx_en);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      check_all_zero("post_reset_idle");
   endtask

   task automatic test_sweep_basic();
      run_check("basic_60_500", 60, 500, 1'b0, -1, 0, 1'b0);
      run_check("single_code", 777, 777, 1'b1, -1, 0, 1'b0);
      run_check("carry_clamp", 65450, 65535, 1'b1, -1, 0, 1'b0);
   endtask

   task automatic test_stall_ovr();
      run_check("stall_100", 60, 500, 1'b0, 100, 20, 1'b1);
   endtask

   task automatic test_fault();
      int j;
      int fc;
      int set_v;
      set_v = 30 + 20 * $urandom_range(0, 2);
      i_set = IW'(set_v);
      i_fid = '0;
      freq_ready = 1'b1;
      j = 2;
      while (10 * j < set_v) j++;
      fc = j + 1;
      start_sweep(60, 500);
      for (int cyc = 1; cyc <= fc + 3; cyc++) begin
         if (cyc > 1) tick();
         i_fid = IW'(10 * cyc);
         n_vec++;
         if (cyc < fc) begin
            if (fault !== 1'b0 || done !== 1'b0 || (cyc >= 2 && tx_en !== 1'b1)) begin
               n_err++;
               $display("[TB] FAIL fault_pre cyc%0d: flt=%b done=%b en=%b, required 0 0 %0d",
                        cyc, fault, done, tx_en, cyc >= 2);
            end
         end else if (fault !== 1'b1 || tx_en !== 1'b0 || freq_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL fault_post cyc%0d: flt=%b en=%b v=%b busy=%b done=%b, required 1 0 0 0 0",
                     cyc, fault, tx_en, freq_valid, busy, done);
         end
      end
      freq_ready = 1'b0;
      i_fid = '0;
      i_set = 32767;
   endtask

   task automatic test_cfg_err();
      start_sweep(500, 60);
      n_vec++;
      if (cfg_err !== 1'b1 || fault !== 1'b0 || busy !== 1'b0 || sync_ovr !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL cfg_err_set: cfg=%b flt=%b busy=%b ovr=%b, required 1 0 0 0",
                  cfg_err, fault, busy, sync_ovr);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_vec++;
         if (freq_valid !== 1'b0 || busy !== 1'b0 || tx_en !== 1'b0 || cfg_err !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL cfg_err_hold: v=%b busy=%b en=%b cfg=%b, required 0 0 0 1",
                     freq_valid, busy, tx_en, cfg_err);
         end
      end
      run_check("after_cfg_err", 60, 500, 1'b1, -1, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int waited;
      waited = 0;
      start_sweep(60, 500);
      while (freq_valid !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      freq_ready = 1'b1;
      tick();
      freq_ready = 1'b0;
      tick();
      n_vec++;
      if (freq_valid !== 1'b0 || tx_en !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL dwell_before_reset: v=%b en=%b busy=%b, required 0 1 1", freq_valid, tx_en, busy);
      end
      rst_n = 1'b0;
      tick();
      check_all_zero("reset_mid_dwell");
      rst_n = 1'b1;
      tick();
      check_all_zero("reset_mid_idle");
      run_check("restart_after_reset", 60, 500, 1'b1, -1, 0, 1'b0);
   endtask

   task automatic test_random();
      int f1;
      int f2;
      for (int n = 0; n < 6; n++) begin
         f1 = $urandom_range(0, 3000);
         f2 = f1 + $urandom_range(0, 1200);
         i_fid = -IW'($urandom_range(1, 1000));
         i_set = IW'($urandom_range(0, 100));
         run_check("random", f1, f2, 1'b1, -1, 0, 1'b0);
      end
      i_fid = '0;
      i_set = 32767;
   endtask

   task automatic test_back_to_back();
      run_check("b2b_first", 1000, 1200, 1'b0, -1, 0, 1'b0);
      run_check("b2b_second", 0, 130, 1'b1, -1, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_sweep_basic();
      test_stall_ovr();
      test_fault();
      test_cfg_err();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
